// File: rtl/mram_pkg.sv
// Shared definitions for the MRAM arbiter: FSM encoding, timeout default,
// and the latched request bundle forwarded to the MRAM controller.
package mram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam logic [11:0] TIMEOUT_DEFAULT = 12'd4000;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dat;
  } req_t;

  // Owner index (0 = m0, 1 = m1) to one-hot vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mram_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick: a lone requester always wins, contention
// goes to the master that was not granted last (last: 0 = m0, 1 = m1).
module rr_arbiter2
  import mram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mram_arbiter.sv
// Two-master Wishbone-classic arbiter in front of a single MRAM controller,
// with round-robin ownership and a bounded wait for the controller's ack.
module mram_arbiter
  import mram_pkg::*;
#(
  parameter logic [11:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m1_stb_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [29:0] m0_adr_i,
  input  logic [29:0] m1_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m1_dat_o,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [29:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_owner;
  logic        r_last;
  logic [11:0] r_count;
  logic        r_s_stb;
  req_t        r_s_req;
  logic [31:0] r_rdata;

  logic [1:0]  w_req;
  logic [1:0]  w_rr_grant;
  logic        w_win;
  req_t        w_m0_req;
  req_t        w_m1_req;
  req_t        w_win_req;
  logic        w_start;
  logic        w_ack;
  logic        w_timeout;
  logic [1:0]  w_owner_oh;
  logic [1:0]  w_ack_vec;
  logic [1:0]  w_err_vec;

  assign w_req = {m1_stb_i, m0_stb_i};

  rr_arbiter2 u_rr (
    .req   (w_req),
    .last  (r_last),
    .grant (w_rr_grant)
  );

  assign w_win     = w_rr_grant[1];
  assign w_m0_req  = '{we: m0_we_i, sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
  assign w_m1_req  = '{we: m1_we_i, sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};
  assign w_win_req = w_win ? w_m1_req : w_m0_req;

  assign w_start   = (r_state == ST_IDLE) && (|w_req);
  assign w_ack     = (r_state == ST_GRANT) && s_ack_i;
  // An ack landing on the final allowed cycle takes precedence over the abort.
  assign w_timeout = (r_state == ST_GRANT) && !s_ack_i && (r_count == TIMEOUT - 12'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_ack) begin
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          w_state_next = ST_ABORT;
        end
      end
      ST_RESP:  w_state_next = ST_IDLE;
      ST_ABORT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Request bundle is frozen at grant time so master-side changes never leak to the slave.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_count <= 12'd0;
      r_s_stb <= 1'b0;
      r_s_req <= '0;
      r_rdata <= 32'h0;
    end else begin
      if (w_start) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_count <= 12'd0;
        r_s_stb <= 1'b1;
        r_s_req <= w_win_req;
      end else if (r_state == ST_GRANT) begin
        r_count <= r_count + 12'd1;
        if (w_ack) begin
          r_rdata <= s_dat_i;
          r_s_stb <= 1'b0;
        end else if (w_timeout) begin
          r_s_stb <= 1'b0;
        end
      end else begin
        r_s_stb <= 1'b0;
      end
    end
  end

  assign s_stb_o = r_s_stb;
  assign s_we_o  = r_s_req.we;
  assign s_sel_o = r_s_req.sel;
  assign s_adr_o = r_s_req.adr;
  assign s_dat_o = r_s_req.dat;

  assign w_owner_oh = onehot2(r_owner);
  assign grant_o    = (r_state == ST_IDLE) ? 2'b00 : w_owner_oh;
  assign w_ack_vec  = (r_state == ST_RESP)  ? w_owner_oh : 2'b00;
  assign w_err_vec  = (r_state == ST_ABORT) ? w_owner_oh : 2'b00;

  assign m0_ack_o = w_ack_vec[0];
  assign m1_ack_o = w_ack_vec[1];
  assign m0_err_o = w_err_vec[0];
  assign m1_err_o = w_err_vec[1];
  assign m0_dat_o = r_rdata;
  assign m1_dat_o = r_rdata;

endmodule
